// File: rtl/kairo_reg_mt.sv
// Multi-task integer register file. It has NTASK banks of 32 x XLEN registers,
// two registered read ports, one shared array write port, and a debug access
// port. A sequencer can zero one task's bank so that a task context can be
// recycled.
module kairo_reg_mt #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NTASK  = 2,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [$clog2(NTASK)-1:0] WTASKNUM,
    input  logic [4:0]               WADDR,
    input  logic                     WE,
    input  logic [XLEN-1:0]          WDATA,
    input  logic [$clog2(NTASK)-1:0] RTASKNUM,
    input  logic [4:0]               RS1ADDR,
    input  logic [4:0]               RS2ADDR,
    output logic [XLEN-1:0]          RS1,
    output logic [XLEN-1:0]          RS2,
    input  logic                     AR_EN,
    input  logic                     AR_WR,
    input  logic [$clog2(NTASK)-1:0] AR_TASK,
    input  logic [4:0]               AR_AD,
    input  logic [XLEN-1:0]          AR_DI,
    output logic [XLEN-1:0]          AR_DO,
    output logic                     AR_ACK,
    input  logic                     CLR_REQ,
    input  logic [$clog2(NTASK)-1:0] CLR_TASK,
    output logic                     CLR_BUSY,
    output logic                     CLR_DONE
);
    localparam int unsigned TW = $clog2(NTASK);
    localparam int unsigned AW = TW + 5;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [TW-1:0]   clr_task_q, clr_task_d;
    logic [XLEN-1:0] mem_q [2**AW];

    logic            ar_go;
    logic            arr_we;
    logic [AW-1:0]   arr_wa;
    logic [XLEN-1:0] arr_wd;
    logic [AW-1:0]   ra1, ra2;
    logic [XLEN-1:0] rd1, rd2;
    logic [XLEN-1:0] rs1_q, rs2_q, ar_do_q;
    logic            ar_ack_q;

    // A debug access runs only in IDLE. A simultaneous clear request takes precedence.
    assign ar_go = (state_q == StIdle) && AR_EN && !CLR_REQ;

    // Clear sequencer next state: IDLE -> CLEAR (r1..r31) -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_task_d = clr_task_q;
        case (state_q)
            StIdle: begin
                if (CLR_REQ) begin
                    state_d    = StClear;
                    cnt_d      = 5'd1;
                    clr_task_d = CLR_TASK;
                end
            end
            StClear: begin
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end
                cnt_d = cnt_q + 5'd1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Write-port arbitration: clear sequencer, then debug access, then core.
    always_comb begin
        arr_we = 1'b0;
        arr_wa = {WTASKNUM, WADDR};
        arr_wd = WDATA;
        if (state_q == StClear) begin
            arr_we = 1'b1;
            arr_wa = {clr_task_q, cnt_q};
            arr_wd = '0;
        end else if (ar_go) begin
            arr_we = AR_WR;
            arr_wa = {AR_TASK, AR_AD};
            arr_wd = AR_DI;
        end else if (!((state_q == StIdle) && AR_EN)) begin
            arr_we = WE;
        end
    end

    // Read-port addressing and data selection. Register 0 reads as zero and
    // same-cycle writes are forwarded.
    always_comb begin
        ra1 = (ar_go && !AR_WR) ? {AR_TASK, AR_AD} : {RTASKNUM, RS1ADDR};
        ra2 = {RTASKNUM, RS2ADDR};
        if (ra1[4:0] == 5'd0) begin
            rd1 = '0;
        end else if (FWD_EN && arr_we && (arr_wa == ra1)) begin
            rd1 = arr_wd;
        end else begin
            rd1 = mem_q[ra1];
        end
        if (ra2[4:0] == 5'd0) begin
            rd2 = '0;
        end else if (FWD_EN && arr_we && (arr_wa == ra2)) begin
            rd2 = arr_wd;
        end else begin
            rd2 = mem_q[ra2];
        end
    end

    // Control state and registered read results.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_task_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            ar_do_q    <= '0;
            ar_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_task_q <= clr_task_d;
            rs1_q      <= rd1;
            rs2_q      <= rd2;
            ar_ack_q   <= ar_go;
            if (ar_go && !AR_WR) begin
                ar_do_q <= rd1;
            end
        end
    end

    // The array has no reset. No write happens in a reset cycle, so an aborted
    // clear stops exactly where it was.
    always_ff @(posedge CLK) begin
        if (RST_N && arr_we) begin
            mem_q[arr_wa] <= arr_wd;
        end
    end

    assign RS1      = rs1_q;
    assign RS2      = rs2_q;
    assign AR_DO    = ar_do_q;
    assign AR_ACK   = ar_ack_q;
    assign CLR_BUSY = (state_q == StClear);
    assign CLR_DONE = (state_q == StDone);

endmodule

// File: tb/tb_kairo_reg_mt.sv
// Directed bench for kairo_reg_mt. It uses three instances: the default build,
// a build without forwarding that shares the same inputs, and a 4-task/64-bit
// build.
module tb_kairo_reg_mt;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic [0:0]  wtask, rtask, ar_task, clr_task;
    logic [4:0]  waddr, rs1a, rs2a, ar_ad;
    logic        we, ar_en, ar_wr, clr_req;
    logic [31:0] wdata, ar_di;
    logic [31:0] rs1, rs2, ar_do, nf_rs1, nf_rs2, nf_ar_do;
    logic        ar_ack, clr_busy, clr_done, nf_ar_ack, nf_clr_busy, nf_clr_done;

    logic [1:0]  b_wtask, b_rtask, b_ar_task, b_clr_task;
    logic [4:0]  b_waddr, b_rs1a, b_rs2a, b_ar_ad;
    logic        b_we, b_ar_en, b_ar_wr, b_clr_req;
    logic [63:0] b_wdata, b_ar_di, b_rs1, b_rs2, b_ar_do;
    logic        b_ar_ack, b_clr_busy, b_clr_done;

    int n_chk = 0;
    int n_fail = 0;

    kairo_reg_mt #(.XLEN(32), .NTASK(2), .FWD_EN(1'b1)) dut (
        .CLK(CLK), .RST_N(rst_n), .WTASKNUM(wtask), .WADDR(waddr), .WE(we), .WDATA(wdata),
        .RTASKNUM(rtask), .RS1ADDR(rs1a), .RS2ADDR(rs2a), .RS1(rs1), .RS2(rs2),
        .AR_EN(ar_en), .AR_WR(ar_wr), .AR_TASK(ar_task), .AR_AD(ar_ad), .AR_DI(ar_di),
        .AR_DO(ar_do), .AR_ACK(ar_ack), .CLR_REQ(clr_req), .CLR_TASK(clr_task),
        .CLR_BUSY(clr_busy), .CLR_DONE(clr_done)
    );

    kairo_reg_mt #(.XLEN(32), .NTASK(2), .FWD_EN(1'b0)) dut_nf (
        .CLK(CLK), .RST_N(rst_n), .WTASKNUM(wtask), .WADDR(waddr), .WE(we), .WDATA(wdata),
        .RTASKNUM(rtask), .RS1ADDR(rs1a), .RS2ADDR(rs2a), .RS1(nf_rs1), .RS2(nf_rs2),
        .AR_EN(ar_en), .AR_WR(ar_wr), .AR_TASK(ar_task), .AR_AD(ar_ad), .AR_DI(ar_di),
        .AR_DO(nf_ar_do), .AR_ACK(nf_ar_ack), .CLR_REQ(clr_req), .CLR_TASK(clr_task),
        .CLR_BUSY(nf_clr_busy), .CLR_DONE(nf_clr_done)
    );

    kairo_reg_mt #(.XLEN(64), .NTASK(4), .FWD_EN(1'b1)) dut4 (
        .CLK(CLK), .RST_N(rst_n), .WTASKNUM(b_wtask), .WADDR(b_waddr), .WE(b_we),
        .WDATA(b_wdata), .RTASKNUM(b_rtask), .RS1ADDR(b_rs1a), .RS2ADDR(b_rs2a),
        .RS1(b_rs1), .RS2(b_rs2), .AR_EN(b_ar_en), .AR_WR(b_ar_wr), .AR_TASK(b_ar_task),
        .AR_AD(b_ar_ad), .AR_DI(b_ar_di), .AR_DO(b_ar_do), .AR_ACK(b_ar_ack),
        .CLR_REQ(b_clr_req), .CLR_TASK(b_clr_task), .CLR_BUSY(b_clr_busy),
        .CLR_DONE(b_clr_done)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic core_wr(input logic [0:0] t, input logic [4:0] a, input logic [31:0] d);
        wtask = t; waddr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_chk++; if (rs1 !== 32'h0) begin n_fail++; $display("FAIL rst_rs1: got %h expected 0", rs1); end
        n_chk++; if (rs2 !== 32'h0) begin n_fail++; $display("FAIL rst_rs2: got %h expected 0", rs2); end
        n_chk++; if (ar_do !== 32'h0) begin n_fail++; $display("FAIL rst_ar_do: got %h expected 0", ar_do); end
        n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ar_ack: got %b expected 0", ar_ack); end
        n_chk++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", clr_busy); end
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", clr_done); end
        n_chk++; if (nf_clr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_nf_busy: got %b expected 0", nf_clr_busy); end
        n_chk++; if (b_ar_do !== 64'h0) begin n_fail++; $display("FAIL rst_b_ar_do: got %h expected 0", b_ar_do); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        core_wr(1'b0, 5'd5, 32'h11111111);
        core_wr(1'b1, 5'd5, 32'hDEADBEEF);
        // Write to r0 while port 2 reads r0 in the same cycle.
        wtask = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; we = 1'b1;
        rtask = 1'b1; rs1a = 5'd5; rs2a = 5'd0;
        step();
        we = 1'b0;
        n_chk++; if (rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_t1r5: got %h expected deadbeef", rs1); end
        n_chk++; if (rs2 !== 32'h0) begin n_fail++; $display("FAIL wr_rd_r0_fwd: got %h expected 0", rs2); end
        rtask = 1'b0; rs1a = 5'd5;
        step();
        n_chk++; if (rs1 !== 32'h11111111) begin n_fail++; $display("FAIL wr_rd_t0r5: got %h expected 11111111", rs1); end
        rtask = 1'b1; rs2a = 5'd0;
        step();
        n_chk++; if (rs2 !== 32'h0) begin n_fail++; $display("FAIL wr_rd_r0: got %h expected 0", rs2); end
        n_chk++; if (nf_rs2 !== 32'h0) begin n_fail++; $display("FAIL wr_rd_nf_r0: got %h expected 0", nf_rs2); end
    endtask

    task automatic test_forward();
        core_wr(1'b0, 5'd7, 32'hAAAA0000);
        wtask = 1'b0; waddr = 5'd7; wdata = 32'h12345678; we = 1'b1;
        rtask = 1'b0; rs1a = 5'd7; rs2a = 5'd7;
        step();
        we = 1'b0;
        n_chk++; if (rs1 !== 32'h12345678) begin n_fail++; $display("FAIL fwd_rs1: got %h expected 12345678", rs1); end
        n_chk++; if (rs2 !== 32'h12345678) begin n_fail++; $display("FAIL fwd_rs2: got %h expected 12345678", rs2); end
        n_chk++; if (nf_rs1 !== 32'hAAAA0000) begin n_fail++; $display("FAIL nofwd_rs1: got %h expected aaaa0000", nf_rs1); end
        step();
        n_chk++; if (nf_rs1 !== 32'h12345678) begin n_fail++; $display("FAIL nofwd_after: got %h expected 12345678", nf_rs1); end
    endtask

    task automatic test_debug();
        core_wr(1'b1, 5'd4, 32'h44);
        // Debug write with a colliding core write that must be dropped.
        ar_en = 1'b1; ar_wr = 1'b1; ar_task = 1'b1; ar_ad = 5'd3; ar_di = 32'h55;
        wtask = 1'b1; waddr = 5'd4; wdata = 32'hBAD; we = 1'b1;
        step();
        ar_en = 1'b0; we = 1'b0;
        n_chk++; if (ar_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_ack: got %b expected 1", ar_ack); end
        n_chk++; if (nf_ar_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_ack_nf: got %b expected 1", nf_ar_ack); end
        rtask = 1'b1; rs1a = 5'd4; rs2a = 5'd3;
        step();
        n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL dbg_ack_pulse: got %b expected 0", ar_ack); end
        n_chk++; if (rs1 !== 32'h44) begin n_fail++; $display("FAIL dbg_core_dropped: got %h expected 44", rs1); end
        n_chk++; if (rs2 !== 32'h55) begin n_fail++; $display("FAIL dbg_wr_data: got %h expected 55", rs2); end
        ar_en = 1'b1; ar_wr = 1'b0; ar_task = 1'b1; ar_ad = 5'd3;
        step();
        n_chk++; if (ar_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_rd_ack: got %b expected 1", ar_ack); end
        n_chk++; if (ar_do !== 32'h55) begin n_fail++; $display("FAIL dbg_rd_do: got %h expected 55", ar_do); end
        n_chk++; if (rs1 !== 32'h55) begin n_fail++; $display("FAIL dbg_rd_port1: got %h expected 55", rs1); end
        n_chk++; if (nf_ar_do !== 32'h55) begin n_fail++; $display("FAIL dbg_rd_do_nf: got %h expected 55", nf_ar_do); end
        // Request held through the ACK: a second access, this time to x0.
        ar_ad = 5'd0;
        step();
        n_chk++; if (ar_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_b2b_ack: got %b expected 1", ar_ack); end
        n_chk++; if (ar_do !== 32'h0) begin n_fail++; $display("FAIL dbg_b2b_x0: got %h expected 0", ar_do); end
        ar_en = 1'b0;
        step();
        n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL dbg_end_ack: got %b expected 0", ar_ack); end
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int i = 1; i < 32; i++) begin
            core_wr(1'b1, 5'(i), 32'h100 + 32'(i));
            core_wr(1'b0, 5'(i), 32'h200 + 32'(i));
        end
        clr_req = 1'b1; clr_task = 1'b1;
        step();
        clr_req = 1'b0;
        n_chk++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_start: got %b expected 1", clr_busy); end
        // First busy cycle: a dropped core write, a waiting debug read, and a read of r1.
        we = 1'b1; wtask = 1'b0; waddr = 5'd2; wdata = 32'hBAD0;
        ar_en = 1'b1; ar_wr = 1'b0; ar_task = 1'b0; ar_ad = 5'd2;
        rtask = 1'b1; rs1a = 5'd1; rs2a = 5'd0;
        step();
        we = 1'b0;
        busy_cycles = 1;
        n_chk++; if (rs1 !== 32'h0) begin n_fail++; $display("FAIL clr_fwd_zero: got %h expected 0", rs1); end
        n_chk++; if (nf_rs1 !== 32'h101) begin n_fail++; $display("FAIL clr_nofwd_old: got %h expected 101", nf_rs1); end
        for (int i = 0; i < 40 && clr_busy; i++) begin
            n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL clr_ar_wait: got %b expected 0", ar_ack); end
            busy_cycles++;
            step();
        end
        n_chk++; if (busy_cycles != 31) begin n_fail++; $display("FAIL clr_busy_len: got %0d expected 31", busy_cycles); end
        n_chk++; if (clr_done !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %b expected 1", clr_done); end
        n_chk++; if (nf_clr_done !== 1'b1) begin n_fail++; $display("FAIL clr_done_nf: got %b expected 1", nf_clr_done); end
        n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL clr_done_ack: got %b expected 0", ar_ack); end
        step();
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_pulse: got %b expected 0", clr_done); end
        n_chk++; if (ar_ack !== 1'b0) begin n_fail++; $display("FAIL clr_idle_ack: got %b expected 0", ar_ack); end
        step();
        ar_en = 1'b0;
        n_chk++; if (ar_ack !== 1'b1) begin n_fail++; $display("FAIL clr_late_ack: got %b expected 1", ar_ack); end
        n_chk++; if (ar_do !== 32'h202) begin n_fail++; $display("FAIL clr_late_do: got %h expected 202", ar_do); end
        rtask = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1a = 5'(i);
            step();
            n_chk++; if (rs1 !== 32'h0) begin n_fail++; $display("FAIL clr_t1_r%0d: got %h expected 0", i, rs1); end
        end
        rtask = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rs1a = 5'(i);
            step();
            n_chk++; if (rs1 !== 32'h200 + 32'(i)) begin n_fail++; $display("FAIL clr_t0_r%0d: got %h expected %h", i, rs1, 32'h200 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 1; i < 32; i++) begin
            core_wr(1'b1, 5'(i), 32'h300 + 32'(i));
        end
        clr_req = 1'b1; clr_task = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_chk++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", clr_busy); end
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", clr_done); end
        step();
        n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_nodone: got %b expected 0", clr_done); end
        rtask = 1'b1;
        for (int i = 1; i < 32; i++) begin
            logic [31:0] exp;
            exp = (i < 10) ? 32'h0 : 32'h300 + 32'(i);
            rs1a = 5'(i);
            step();
            n_chk++; if (rs1 !== exp) begin n_fail++; $display("FAIL mid_rst_r%0d: got %h expected %h", i, rs1, exp); end
        end
    endtask

    task automatic test_wide();
        b_wtask = 2'd3; b_waddr = 5'd31; b_wdata = 64'h0123456789ABCDEF; b_we = 1'b1;
        step();
        b_we = 1'b0;
        b_rtask = 2'd3; b_rs1a = 5'd31; b_rs2a = 5'd31;
        step();
        n_chk++; if (b_rs1 !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL wide_rd: got %h expected 0123456789abcdef", b_rs1); end
        b_clr_req = 1'b1; b_clr_task = 2'd2;
        step();
        b_clr_req = 1'b0;
        n_chk++; if (b_clr_busy !== 1'b1) begin n_fail++; $display("FAIL wide_busy: got %b expected 1", b_clr_busy); end
        for (int i = 0; i < 40 && b_clr_busy; i++) begin
            step();
            n_chk++; if (b_rs1 !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL wide_stable: got %h expected 0123456789abcdef", b_rs1); end
        end
        n_chk++; if (b_clr_done !== 1'b1) begin n_fail++; $display("FAIL wide_done: got %b expected 1", b_clr_done); end
        b_rtask = 2'd2; b_rs1a = 5'd31; b_rs2a = 5'd0;
        step();
        n_chk++; if (b_rs1 !== 64'h0) begin n_fail++; $display("FAIL wide_t2_r31: got %h expected 0", b_rs1); end
        n_chk++; if (b_rs2 !== 64'h0) begin n_fail++; $display("FAIL wide_t2_r0: got %h expected 0", b_rs2); end
        n_chk++; if (b_ar_ack !== 1'b0) begin n_fail++; $display("FAIL wide_ack: got %b expected 0", b_ar_ack); end
    endtask

    initial begin
        rst_n = 1'b0;
        wtask = '0; rtask = '0; ar_task = '0; clr_task = '0;
        waddr = '0; rs1a = '0; rs2a = '0; ar_ad = '0;
        we = 1'b0; ar_en = 1'b0; ar_wr = 1'b0; clr_req = 1'b0;
        wdata = '0; ar_di = '0;
        b_wtask = '0; b_rtask = '0; b_ar_task = '0; b_clr_task = '0;
        b_waddr = '0; b_rs1a = '0; b_rs2a = '0; b_ar_ad = '0;
        b_we = 1'b0; b_ar_en = 1'b0; b_ar_wr = 1'b0; b_clr_req = 1'b0;
        b_wdata = '0; b_ar_di = '0;
        test_reset();
        test_write_read();
        test_forward();
        test_debug();
        test_clear();
        test_reset_mid_clear();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
